// File: rtl/io_pkg.sv
// Shared definitions for the IO-side blocks: loader state encoding, frame header size and
// default sizing constants reused by other IO blocks.
package io_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLenHi,
    StLenLo,
    StData,
    StCheck,
    StDone,
    StErr
  } loader_state_t;

  localparam int unsigned LEN_BYTES              = 2;
  localparam int unsigned DEFAULT_ADDR_W         = 16;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1_000_000;

endpackage

// File: rtl/uart_ram_loader_if.sv
// Byte-stream input and RAM write-port signals of the UART RAM loader.
// The master modport is the loader itself; the slave modport is its environment.
interface uart_ram_loader_if import io_pkg::*; #(
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) ();

  logic              start;
  logic              rx_done;
  logic [7:0]        rx_byte;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_din;
  logic              ram_we;
  logic              busy;
  logic              load_done;
  logic              load_err;
  logic [ADDR_W-1:0] byte_count;

  modport master (
    input  start, rx_done, rx_byte,
    output ram_addr, ram_din, ram_we, busy, load_done, load_err, byte_count
  );

  modport slave (
    output start, rx_done, rx_byte,
    input  ram_addr, ram_din, ram_we, busy, load_done, load_err, byte_count
  );

endinterface

// File: rtl/rx_gap_timer.sv
// Inter-byte gap timer: reloads on clear or while disabled, counts down while enabled and
// flags expiry for one cycle when it reaches zero.
module rx_gap_timer import io_pkg::*; #(
  parameter int unsigned CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = (CYCLES > 2) ? $clog2(CYCLES) : 1;
  localparam logic [CntW-1:0] Reload = CntW'(CYCLES - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= Reload;
    end else if (clear || !enable) begin
      cnt_q <= Reload;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // A byte arriving in the expiry cycle takes priority over the timeout.
  assign expired = enable && !clear && (cnt_q == '0);

endmodule

// File: rtl/uart_ram_loader.sv
// Parses a length/payload/XOR-checksum frame from the UART byte stream and writes the
// payload to RAM from address 0, then reports completion with a sticky error flag.
module uart_ram_loader import io_pkg::*; #(
  parameter int unsigned ADDR_W         = DEFAULT_ADDR_W,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input logic               clk,
  input logic               reset,
  uart_ram_loader_if.master bus
);

  localparam int unsigned LenW = 8 * LEN_BYTES;

  loader_state_t     state_q;
  logic [LenW-1:0]   len_q;
  logic [ADDR_W-1:0] count_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [7:0]        ram_din_q;
  logic [7:0]        csum_q;
  logic              ram_we_q;
  logic              busy_q;
  logic              load_done_q;
  logic              load_err_q;
  logic              in_frame;
  logic              expired;
  logic              last_byte;

  assign in_frame  = state_q inside {StLenHi, StLenLo, StData, StCheck};
  assign last_byte = (32'(count_q) + 32'd1) == 32'(len_q);

  rx_gap_timer #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (bus.rx_done),
    .enable  (in_frame),
    .expired (expired)
  );

  // The write pointer and the reported byte count are always equal, so one register serves both.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      len_q       <= '0;
      count_q     <= '0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      csum_q      <= '0;
      ram_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      ram_we_q    <= 1'b0;
      load_done_q <= 1'b0;
      busy_q      <= (state_q != StIdle);
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q    <= StLenHi;
            busy_q     <= 1'b1;
            load_err_q <= 1'b0;
            count_q    <= '0;
            csum_q     <= '0;
          end
        end
        StLenHi: begin
          if (bus.rx_done) begin
            len_q[LenW-1:8] <= bus.rx_byte;
            state_q         <= StLenLo;
          end else if (expired) begin
            state_q <= StErr;
          end
        end
        StLenLo: begin
          if (bus.rx_done) begin
            len_q[7:0] <= bus.rx_byte;
            state_q    <= ({len_q[LenW-1:8], bus.rx_byte} == '0) ? StCheck : StData;
          end else if (expired) begin
            state_q <= StErr;
          end
        end
        StData: begin
          if (bus.rx_done) begin
            ram_addr_q <= count_q;
            ram_din_q  <= bus.rx_byte;
            ram_we_q   <= 1'b1;
            csum_q     <= csum_q ^ bus.rx_byte;
            count_q    <= count_q + 1'b1;
            if (last_byte) begin
              state_q <= StCheck;
            end
          end else if (expired) begin
            state_q <= StErr;
          end
        end
        StCheck: begin
          if (bus.rx_done) begin
            state_q <= (bus.rx_byte == csum_q) ? StDone : StErr;
          end else if (expired) begin
            state_q <= StErr;
          end
        end
        StDone: begin
          load_done_q <= 1'b1;
          state_q     <= StIdle;
        end
        StErr: begin
          load_err_q  <= 1'b1;
          load_done_q <= 1'b1;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_din    = ram_din_q;
  assign bus.ram_we     = ram_we_q;
  assign bus.busy       = busy_q;
  assign bus.load_done  = load_done_q;
  assign bus.load_err   = load_err_q;
  assign bus.byte_count = count_q;

endmodule

// File: tb/tb_uart_ram_loader.sv
// Scoreboard bench for uart_ram_loader: a frame model queues expected RAM writes and
// completions; a negedge monitor pops and compares them as the DUT produces them.
module tb_uart_ram_loader;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   last_rx_cyc = 0;
  bit   chk_gap = 1'b0;
  bit   chk_busy_fall = 1'b0;

  int         exp_addr[$];
  logic [7:0] exp_data[$];
  bit         exp_err[$];
  int         exp_cnt[$];
  logic [7:0] fr[$];

  uart_ram_loader_if #(.ADDR_W(16)) bus ();

  uart_ram_loader #(
    .ADDR_W         (16),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor / scoreboard consumer.
  always @(negedge clk) begin
    if (bus.rx_done) last_rx_cyc = cyc;
    if (chk_busy_fall) begin
      check("busy_fall", 32'(bus.busy), 32'd0);
      chk_busy_fall = 1'b0;
    end
    if (bus.ram_we) begin
      if (exp_addr.size() == 0) begin
        check("wr_unexpected", 32'(bus.ram_we), 32'd0);
      end else begin
        check("wr_addr", 32'(bus.ram_addr), 32'(exp_addr.pop_front()));
        check("wr_data", 32'(bus.ram_din), 32'(exp_data.pop_front()));
      end
    end
    if (bus.load_done) begin
      if (exp_err.size() == 0) begin
        check("done_unexpected", 32'(bus.load_done), 32'd0);
      end else begin
        check("load_err", 32'(bus.load_err), 32'(exp_err.pop_front()));
        check("byte_count", 32'(bus.byte_count), 32'(exp_cnt.pop_front()));
        check("busy_at_done", 32'(bus.busy), 32'd1);
        if (chk_gap) begin
          check("timeout_gap", 32'(cyc - last_rx_cyc), 32'd66);
          chk_gap = 1'b0;
        end
        chk_busy_fall = 1'b1;
      end
    end
  end

  // Reference model of a complete frame: writes, checksum verdict and final count.
  task automatic push_expect(input logic [7:0] f[$]);
    int len;
    logic [7:0] cs;
    len = int'({f[0], f[1]});
    cs  = 8'h00;
    for (int i = 0; i < len; i++) begin
      exp_addr.push_back(i);
      exp_data.push_back(f[2+i]);
      cs ^= f[2+i];
    end
    exp_err.push_back(f[2+len] != cs);
    exp_cnt.push_back(len);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #2;
    bus.rx_byte = b;
    bus.rx_done = 1'b1;
    @(posedge clk); #2;
    bus.rx_done = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] f[$]);
    foreach (f[i]) send_byte(f[i]);
  endtask

  task automatic do_start();
    @(posedge clk); #2;
    bus.start = 1'b1;
    @(posedge clk); #2;
    bus.start = 1'b0;
    @(negedge clk);
    check("busy_rise", 32'(bus.busy), 32'd1);
    check("err_cleared", 32'(bus.load_err), 32'd0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_err.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    check("done_seen", 32'(exp_err.size()), 32'd0);
    check("writes_drained", 32'(exp_addr.size()), 32'd0);
    repeat (3) @(posedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"}, 32'(bus.ram_addr), 32'd0);
    check({tag, "_din"}, 32'(bus.ram_din), 32'd0);
    check({tag, "_we"}, 32'(bus.ram_we), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.load_done), 32'd0);
    check({tag, "_err"}, 32'(bus.load_err), 32'd0);
    check({tag, "_count"}, 32'(bus.byte_count), 32'd0);
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.rx_done = 1'b0;
    bus.rx_byte = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk); #2;
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // Good frame.
    fr = '{8'h00, 8'h03, 8'hA5, 8'h5A, 8'hFF, 8'h00};
    do_start();
    push_expect(fr);
    send_frame(fr);
    wait_done();

    // Bad checksum; error flag stays up until the next start.
    fr = '{8'h00, 8'h03, 8'hA5, 8'h5A, 8'hFF, 8'h01};
    do_start();
    push_expect(fr);
    send_frame(fr);
    wait_done();
    @(negedge clk);
    check("err_sticky", 32'(bus.load_err), 32'd1);

    // Zero length.
    fr = '{8'h00, 8'h00, 8'h00};
    do_start();
    push_expect(fr);
    send_frame(fr);
    wait_done();

    // Stray byte in IDLE, then a good frame with a second start pulse mid-payload.
    send_byte(8'h77);
    fr = '{8'h00, 8'h03, 8'h12, 8'h34, 8'h56, 8'h70};
    do_start();
    push_expect(fr);
    for (int i = 0; i < 3; i++) send_byte(fr[i]);
    do_start();
    for (int i = 3; i < 6; i++) send_byte(fr[i]);
    wait_done();

    // Timeout after the first payload byte.
    do_start();
    exp_addr.push_back(0);
    exp_data.push_back(8'h11);
    exp_err.push_back(1'b1);
    exp_cnt.push_back(1);
    chk_gap = 1'b1;
    send_byte(8'h00);
    send_byte(8'h05);
    send_byte(8'h11);
    wait_done();

    // Reset in the middle of the payload, then a clean frame.
    do_start();
    exp_addr.push_back(0);
    exp_data.push_back(8'hA5);
    exp_addr.push_back(1);
    exp_data.push_back(8'h5A);
    send_byte(8'h00);
    send_byte(8'h03);
    send_byte(8'hA5);
    send_byte(8'h5A);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    check("midrst_wr_drained", 32'(exp_addr.size()), 32'd0);
    repeat (2) @(posedge clk); #2;
    reset = 1'b1;
    fr = '{8'h00, 8'h03, 8'hA5, 8'h5A, 8'hFF, 8'h00};
    do_start();
    push_expect(fr);
    send_frame(fr);
    wait_done();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
    $fatal(1);
  end

endmodule

// File: doc/uart_ram_loader.md
# uart_ram_loader

Byte-stream loader between `UART_RX` and the shared data RAM port. It consumes `rx_byte`/`rx_done` strobes and parses a frame: a 16-bit big-endian length, then payload bytes, then an XOR checksum byte. Payload bytes are written to consecutive RAM addresses starting at 0, and the loader then reports completion so the IO sequencer can release the processor. It drives the IO side of the RAM address, write-data and write-enable muxes.

## Interface
Parameters:
- `ADDR_W`, 16, RAM address width; payload length is capped at 2^ADDR_W − 1.
- `TIMEOUT_CYCLES`, 1_000_000, maximum number of idle `clk` cycles allowed between received bytes inside a frame.

Ports:
- `clk` in 1: single clock; the same clock that drives `UART_RX` and the RAM.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: arm the loader; sampled only in IDLE.
- `rx_done` in 1: one-cycle strobe from `UART_RX`; `rx_byte` is valid in the same cycle.
- `rx_byte` in 8: received byte.
- `ram_addr` out ADDR_W: RAM write address.
- `ram_din` out 8: RAM write data.
- `ram_we` out 1: RAM write enable; one-cycle pulse per payload byte.
- `busy` out 1: high in every state except IDLE.
- `load_done` out 1: one-cycle pulse at frame end, for success or error.
- `load_err` out 1: sticky error flag; valid from the `load_done` pulse and cleared by the next accepted `start`.
- `byte_count` out ADDR_W: number of payload bytes written in the current or last frame.

## Operation
- The state machine has seven states: IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERR.
- IDLE:
  - `start` moves to LEN_HI and clears `load_err`, `byte_count`, the checksum register and the address pointer.
  - `rx_done` is ignored in IDLE.
- LEN_HI: on `rx_done`, `len[15:8]` ← `rx_byte`; move to LEN_LO.
- LEN_LO: on `rx_done`, `len[7:0]` ← `rx_byte`. If the assembled length is 0, move to CHECK; otherwise move to DATA.
- DATA, on each `rx_done`:
  - register `ram_addr` ← pointer, `ram_din` ← `rx_byte`, `ram_we` ← 1;
  - `csum` ← `csum ^ rx_byte`; pointer and `byte_count` increment.
  - After the write at pointer = len−1, move to CHECK.
- CHECK: on `rx_done`, compare `rx_byte` with `csum`. On match move to DONE; on mismatch move to ERR.
- DONE: pulse `load_done` with `load_err` = 0, then return to IDLE.
- ERR: set `load_err` = 1, pulse `load_done`, then return to IDLE. RAM contents already written are not rolled back.
- The checksum is the XOR of payload bytes only; the header bytes are excluded.
- Pointer arithmetic is unsigned ADDR_W-bit. It cannot wrap, because len ≤ 2^ADDR_W − 1.
- Timeout:
  - In LEN_HI, LEN_LO, DATA and CHECK, a gap counter clears on every `rx_done` and increments otherwise.
  - When the count reaches `TIMEOUT_CYCLES` − 1, move to ERR.
- Boundary and conflict rules:
  - `start` while busy is ignored.
  - If `rx_done` and timeout expiry occur in the same cycle, `rx_done` wins and the counter clears.
  - Reset asserted mid-frame returns the block to IDLE immediately with all outputs at their reset values; a partial frame is abandoned.

## Timing
- Reset values: `ram_addr` = 0, `ram_din` = 0, `ram_we` = 0, `busy` = 0, `load_done` = 0, `load_err` = 0, `byte_count` = 0, state = IDLE.
- All outputs are registered; there are no combinational paths from input to output.
- Write latency: `rx_done` in cycle N in DATA produces `ram_we` high in N+1, with `ram_addr` and `ram_din` stable in N+1.
- `busy` rises in the cycle after `start` is sampled.
- Completion: `load_done` pulses 2 cycles after the checksum `rx_done` (CHECK→DONE/ERR, then the DONE/ERR output cycle). `busy` falls in the cycle after `load_done`.
- Timeout: `load_done` pulses 2 cycles after the counter reaches its limit.
- Minimum spacing between `rx_done` strobes is 2 cycles. The UART byte time guarantees this.

## Structure
- Shared package `io_pkg` holds:
  - the state enum `loader_state_t`;
  - `LEN_BYTES` = 2;
  - default constants for `TIMEOUT_CYCLES` and `ADDR_W`, which other IO blocks reuse.
- One sub-module, `rx_gap_timer`: a parameterised down-counter with inputs `clear` and `enable`, and a one-cycle `expired` output.
- Everything else sits in one FSM with datapath registers.

## Test plan
- Good frame: `start`, then bytes 00 03 A5 5A FF 00.
  - Required: `ram_we` pulses write A5@0, 5A@1, FF@2.
  - Required: `load_done` pulses with `load_err` = 0, and `byte_count` = 3.
- Bad checksum: same frame ending with 01.
  - Required: three writes, then `load_done` with `load_err` = 1.
- Zero length: bytes 00 00 00.
  - Required: no `ram_we` pulse, `load_done` with `load_err` = 0, `byte_count` = 0.
- Timeout: `TIMEOUT_CYCLES` = 64; send 00 05 11, then stay silent.
  - Required: one write at address 0, and `load_done` with `load_err` = 1 exactly 64 + 2 cycles after the last `rx_done`.
- Reset mid-DATA: assert reset after the 2nd payload byte.
  - Required: all outputs return to their reset values at once.
  - Required: a following full good frame completes cleanly.
- Ignored inputs: pulse `start` again during DATA, and pulse `rx_done` while in IDLE.
  - Required: no effect on state, pointer, `csum` or RAM writes.
